// File: rtl/state_machine.sv
// state_machine -- multi-cycle RV32I main control FSM.
//
// Each instruction goes through FETCH -> DECODE -> EXEC. Loads add a MEM
// stage before returning to FETCH. Only the state register is clocked. All
// datapath controls are decoded combinationally from the registered state and
// the instruction word:
//   - In DECODE, the opcode comes from data_from_mem, because the IR is still
//     being loaded.
//   - In EXEC and MEM, every field comes from `instruction` (the IR).
//
// Optional build macro: UNKNOWN_OP_NOP_EN
//   defined   : an unknown opcode runs as a 3-cycle NOP (EXEC asserts PCen only).
//   undefined : an unknown opcode goes from DECODE to HALT (state 15). HALT
//               drives all outputs 0 and is left only through rst.
// A load or store with an unsupported funct3 counts as an unknown opcode.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   instruction[31:0] IR contents
//   data_from_mem     memory read bus (fetched word during DECODE)
//   FLAGS[4:0]        latched compare flags {V, N, LTU, LT, EQ}
//   branch, jump      PC strobes for a taken branch and for JAL/JALR
//   PCen, IEn         PC update enable and IR load enable
//   Ren[31:0]         one-hot register-file write enable (zero for rd = x0)
//   RegOrImm          ALU operand B select (1 = immediate)
//   WE                data memory write enable
//   ALU_MUX_CNTL      writeback select (1 = data_from_mem)
//   LS_CNTL           memory address select (1 = ALU result)
//   flagEn            latch ALU flags
//   state_counter     current state code, exposed for debug
module state_machine (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] data_from_mem,
  input  logic [4:0]  FLAGS,
  output logic        branch,
  output logic        jump,
  output logic        PCen,
  output logic [31:0] Ren,
  output logic        RegOrImm,
  output logic        WE,
  output logic        IEn,
  output logic        ALU_MUX_CNTL,
  output logic        LS_CNTL,
  output logic        flagEn,
  output logic [3:0]  state_counter
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_HALT   = 4'd15
  } state_t;

  state_t state;
  state_t next_state;

  logic [6:0]  ir_op;
  logic [2:0]  ir_f3;
  logic [4:0]  ir_rd;
  logic [31:0] rd_onehot;
  logic [6:0]  mem_op;
  logic [2:0]  mem_f3;
  logic        mem_known;
  logic        take_branch;
  logic        unused_bits;

  assign ir_op  = instruction[6:0];
  assign ir_f3  = instruction[14:12];
  assign ir_rd  = instruction[11:7];
  assign mem_op = data_from_mem[6:0];
  assign mem_f3 = data_from_mem[14:12];

  // x0 is hardwired to zero, so it never receives a write enable.
  assign rd_onehot = (ir_rd == 5'd0) ? 32'd0 : (32'd1 << ir_rd);

  // Fields this unit does not look at.
  assign unused_bits = ^{instruction[31:15], data_from_mem[31:15],
                         data_from_mem[11:7], FLAGS[4:3]};

  // Decides in DECODE whether the fetched word is something we can execute.
  function automatic logic op_known(input logic [6:0] op, input logic [2:0] f3);
    logic known;
    known = 1'b0;
    case (op)
      OP_R, OP_I, OP_LUI, OP_AUIPC,
      OP_BRANCH, OP_JAL, OP_JALR: known = 1'b1;
      OP_LOAD:  known = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                        (f3 == 3'b100) || (f3 == 3'b101);
      OP_STORE: known = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      default:  known = 1'b0;
    endcase
    return known;
  endfunction

  assign mem_known = op_known(mem_op, mem_f3);

  always_comb begin
    take_branch = 1'b0;
    case (ir_f3)
      3'b000:  take_branch =  FLAGS[0];  // BEQ
      3'b001:  take_branch = ~FLAGS[0];  // BNE
      3'b100:  take_branch =  FLAGS[1];  // BLT
      3'b101:  take_branch = ~FLAGS[1];  // BGE
      3'b110:  take_branch =  FLAGS[2];  // BLTU
      3'b111:  take_branch = ~FLAGS[2];  // BGEU
      default: take_branch = 1'b0;
    endcase
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
`ifdef UNKNOWN_OP_NOP_EN
      S_DECODE: next_state = S_EXEC;
`else
      S_DECODE: next_state = mem_known ? S_EXEC : S_HALT;
`endif
      S_EXEC:   next_state = (ir_op == OP_LOAD) ? S_MEM : S_FETCH;
      S_MEM:    next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  assign state_counter = state;

  // Reset forces FETCH, and FETCH decodes to all-zero outputs. That is what
  // makes the outputs drop to 0 as soon as rst rises.
  always_comb begin
    branch       = 1'b0;
    jump         = 1'b0;
    PCen         = 1'b0;
    Ren          = 32'd0;
    RegOrImm     = 1'b0;
    WE           = 1'b0;
    IEn          = 1'b0;
    ALU_MUX_CNTL = 1'b0;
    LS_CNTL      = 1'b0;
    flagEn       = 1'b0;
    case (state)
      S_FETCH: LS_CNTL = 1'b0;  // memory read at PC
      S_DECODE: begin
        IEn    = 1'b1;
        flagEn = (mem_op == OP_BRANCH);
      end
      S_EXEC: begin
        case (ir_op)
          OP_R, OP_I, OP_LUI, OP_AUIPC: begin
            RegOrImm = (ir_op != OP_R);
            Ren      = rd_onehot;
            PCen     = 1'b1;
          end
          OP_LOAD: begin
            RegOrImm = 1'b1;
            LS_CNTL  = 1'b1;
          end
          OP_STORE: begin
            RegOrImm = 1'b1;
            LS_CNTL  = 1'b1;
            WE       = 1'b1;
            PCen     = 1'b1;
          end
          OP_BRANCH: begin
            branch = take_branch;
            PCen   = 1'b1;
          end
          OP_JAL, OP_JALR: begin
            jump     = 1'b1;
            Ren      = rd_onehot;
            PCen     = 1'b1;
            RegOrImm = (ir_op == OP_JALR);
          end
          default: begin
`ifdef UNKNOWN_OP_NOP_EN
            PCen = 1'b1;
`endif
          end
        endcase
      end
      S_MEM: begin
        LS_CNTL      = 1'b1;
        ALU_MUX_CNTL = 1'b1;
        Ren          = rd_onehot;
        PCen         = 1'b1;
      end
      default: ;  // HALT: everything stays 0
    endcase
  end

endmodule

// File: tb/tb_state_machine.sv
// Directed bench for state_machine. The control bundle is packed as
// {branch, jump, PCen, RegOrImm, WE, IEn, ALU_MUX_CNTL, LS_CNTL, flagEn}.
module tb_state_machine;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] data_from_mem;
  logic [4:0]  FLAGS;
  logic        branch, jump, PCen, RegOrImm, WE, IEn;
  logic        ALU_MUX_CNTL, LS_CNTL, flagEn;
  logic [31:0] Ren;
  logic [3:0]  state_counter;

  int n_checks = 0;
  int n_fail   = 0;

  state_machine dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .data_from_mem(data_from_mem), .branch(branch), .jump(jump),
    .FLAGS(FLAGS), .PCen(PCen), .Ren(Ren), .RegOrImm(RegOrImm), .WE(WE),
    .IEn(IEn), .ALU_MUX_CNTL(ALU_MUX_CNTL), .LS_CNTL(LS_CNTL),
    .flagEn(flagEn), .state_counter(state_counter)
  );

  // ---------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------
  // Checking and driver tasks
  // ---------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctl();
    return {branch, jump, PCen, RegOrImm, WE, IEn, ALU_MUX_CNTL, LS_CNTL, flagEn};
  endfunction

  task automatic expect_cycle(input string tag, input logic [3:0] st,
                              input logic [8:0] c, input logic [31:0] ren);
    check({tag, ".state"}, {28'd0, state_counter}, {28'd0, st});
    check({tag, ".ctl"},   {23'd0, ctl()},         {23'd0, c});
    check({tag, ".ren"},   Ren,                    ren);
  endtask

  // Sample 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // The bench stands in for the IR: both buses carry the word from FETCH on.
  task automatic load_word(input logic [31:0] w);
    instruction   = w;
    data_from_mem = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_cycle("reset", 4'd0, 9'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one whole non-load instruction. The bench is in FETCH when this
  // is called, and is back in FETCH when it returns.
  task automatic run3(input string tag, input logic [31:0] w,
                      input logic [8:0] dec_c, input logic [8:0] ex_c,
                      input logic [31:0] ex_ren);
    load_word(w);
    expect_cycle({tag, ".f"}, 4'd0, 9'b0, 32'd0);
    step();
    expect_cycle({tag, ".d"}, 4'd1, dec_c, 32'd0);
    step();
    expect_cycle({tag, ".e"}, 4'd2, ex_c, ex_ren);
    step();
    check({tag, ".back"}, {28'd0, state_counter}, 32'd0);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    instruction = 32'd0;
    data_from_mem = 32'd0;
    FLAGS = 5'd0;
    #12;
    expect_cycle("por", 4'd0, 9'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // R-type, I-type and the x0 / x31 boundaries of the write enable.
    run3("add",  32'h002081B3, 9'b000001000, 9'b001000000, 32'h0000_0008);
    run3("addi", 32'h02A08193, 9'b000001000, 9'b001100000, 32'h0000_0008);
    run3("srai", 32'h4020D193, 9'b000001000, 9'b001100000, 32'h0000_0008);
    run3("nop0", 32'h00000013, 9'b000001000, 9'b001100000, 32'h0000_0000);
    run3("add31", 32'h00000FB3, 9'b000001000, 9'b001000000, 32'h8000_0000);

    // LW goes through all four states.
    load_word(32'h02A0A183);
    expect_cycle("lw.f", 4'd0, 9'b0, 32'd0);
    step(); expect_cycle("lw.d", 4'd1, 9'b000001000, 32'd0);
    step(); expect_cycle("lw.e", 4'd2, 9'b000100010, 32'd0);
    step(); expect_cycle("lw.m", 4'd3, 9'b001000110, 32'h0000_0008);
    step(); check("lw.back", {28'd0, state_counter}, 32'd0);

    // SW
    run3("sw", 32'h0020A023, 9'b000001000, 9'b001110010, 32'd0);

    // Branches. flagEn is only raised in DECODE.
    FLAGS = 5'b00001;
    run3("beq_t",  32'h00208063, 9'b000001001, 9'b101000000, 32'd0);
    FLAGS = 5'b00000;
    run3("beq_nt", 32'h00208063, 9'b000001001, 9'b001000000, 32'd0);
    run3("bgeu_t", 32'h0020F063, 9'b000001001, 9'b101000000, 32'd0);
    FLAGS = 5'b00100;
    run3("bgeu_nt", 32'h0020F063, 9'b000001001, 9'b001000000, 32'd0);
    FLAGS = 5'b00001;
    run3("bne_nt", 32'h00209063, 9'b000001001, 9'b001000000, 32'd0);
    FLAGS = 5'b00000;

    // JAL
    run3("jal", 32'h000001EF, 9'b000001000, 9'b011000000, 32'h0000_0008);

    // Reset raised in the middle of DECODE takes effect without a clock edge.
    load_word(32'h000001EF);
    step();
    check("jal2.d", {28'd0, state_counter}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    expect_cycle("midrst", 4'd0, 9'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Unknown opcode (FENCE)
`ifdef UNKNOWN_OP_NOP_EN
    run3("fence", 32'h0000000F, 9'b000001000, 9'b001000000, 32'd0);
    run3("ld_bad", 32'h0000B183, 9'b000001000, 9'b001000000, 32'd0);
`else
    load_word(32'h0000000F);
    step(); expect_cycle("fence.d", 4'd1, 9'b000001000, 32'd0);
    step(); expect_cycle("fence.h", 4'd15, 9'b0, 32'd0);
    step(); step();
    expect_cycle("fence.hold", 4'd15, 9'b0, 32'd0);
    do_reset();
    #1;

    // A load with an unsupported funct3 also halts.
    load_word(32'h0000B183);
    step(); expect_cycle("ld_bad.d", 4'd1, 9'b000001000, 32'd0);
    step(); expect_cycle("ld_bad.h", 4'd15, 9'b0, 32'd0);
    do_reset();
    #1;
`endif

    // The core runs normally again after that.
    run3("add_end", 32'h002081B3, 9'b000001000, 9'b001000000, 32'h0000_0008);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
